// File: rtl/imem_port_arbiter.sv
// Shares the instruction memory's single combinational read port between the
// fetch (F) and debug (D) requesters, one ACCESS/RESP transaction at a time.
module imem_port_arbiter #(
  parameter int MEM_BYTES = 400,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_adrs,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  input  logic          d_req,
  input  logic [AW-1:0] d_adrs,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_adrs,
  input  logic [DW-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic          take, take_d;
  logic          owner_d_p0, last_d, err_p0;
  logic [AW-1:0] adrs_sel, adrs_p0;

  // Misaligned or beyond the last full word of the memory.
  function automatic logic adrs_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || (a > AW'(MEM_BYTES - 4));
  endfunction

  // On a tie the port that was not served last wins.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    take_d    = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (f_req || d_req) begin
          take      = 1'b1;
          take_d    = d_req && (!f_req || !last_d);
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  assign adrs_sel = take_d ? d_adrs : f_adrs;

  // Stage p0: request latched at the granting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_d     <= 1'b1;
      owner_d_p0 <= 1'b0;
      err_p0     <= 1'b0;
      f_rdata    <= '0;
      f_err      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner_d_p0 <= take_d;
        last_d     <= take_d;
        err_p0     <= adrs_bad(adrs_sel);
      end
      // Stage p1: memory word captured at the end of the ACCESS cycle.
      if (state == ACCESS) begin
        if (owner_d_p0) begin
          d_rdata <= err_p0 ? '0 : mem_data;
          d_err   <= err_p0;
        end else begin
          f_rdata <= err_p0 ? '0 : mem_data;
          f_err   <= err_p0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) adrs_p0 <= adrs_sel;
  end

  // The memory only ever sees a checked address, and only during ACCESS.
  assign mem_adrs = (state == ACCESS && !err_p0) ? adrs_p0 : '0;
  assign f_gnt    = (state == ACCESS) && !owner_d_p0;
  assign d_gnt    = (state == ACCESS) &&  owner_d_p0;
  assign f_rvalid = (state == RESP)   && !owner_d_p0;
  assign d_rvalid = (state == RESP)   &&  owner_d_p0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, a hand-written address
// change sequence, then randomized traffic against a transaction-level model.
module tb_imem_port_arbiter;

  localparam int MEM_BYTES = 400;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst_n;
  logic          f_req, f_gnt, f_rvalid, f_err;
  logic [AW-1:0] f_adrs;
  logic [DW-1:0] f_rdata;
  logic          d_req, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_adrs;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_adrs;
  logic [DW-1:0] mem_data;

  logic [7:0] mem [0:MEM_BYTES-1];

  int n_chk = 0;
  int n_err = 0;

  imem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_adrs(f_adrs), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_adrs(d_adrs), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_adrs(mem_adrs), .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Big-endian combinational memory read port.
  always_comb begin
    int unsigned a;
    a = mem_adrs;
    mem_data = '0;
    if (a <= MEM_BYTES - 4)
      mem_data = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  end

  logic [101:0] act;
  assign act = {f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, d_err, mem_adrs};

  function automatic logic [101:0] pk(input bit fg, frv, input logic [31:0] frd, input bit fe,
                                      input bit dg, drv, input logic [31:0] drd, input bit de,
                                      input logic [31:0] ma);
    return {fg, frv, frd, fe, dg, drv, drd, de, ma};
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic chk(input string name, input logic [101:0] got, input logic [101:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit           rn;
    bit           fr;
    logic [31:0]  fa;
    bit           dr;
    logic [31:0]  da;
    logic [101:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rn, fr, input logic [31:0] fa, input bit dr,
                     input logic [31:0] da, input logic [101:0] exp);
    vec_t v;
    v.rn = rn; v.fr = fr; v.fa = fa; v.dr = dr; v.da = da; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Transaction-level reference: a port transaction occupies the cycle after
  // its granting edge (grant) and the one after that (response).
  bit          m_busy, m_own_d, m_last_d, m_err;
  logic [31:0] m_adrs;
  bit          e_fg, e_frv, e_fe, e_dg, e_drv, e_de;
  logic [31:0] e_frd, e_drd, e_mem;

  task automatic model_step(input bit rn, fr, input logic [31:0] fa, input bit dr,
                            input logic [31:0] da);
    e_fg = 0; e_frv = 0; e_dg = 0; e_drv = 0; e_mem = 0;
    if (!rn) begin
      m_busy = 0; m_last_d = 1;
      e_frd = 0; e_fe = 0; e_drd = 0; e_de = 0;
    end else if (m_busy) begin
      m_busy = 0;
      if (m_own_d) begin
        e_drv = 1; e_drd = m_err ? 32'd0 : ref_word(m_adrs); e_de = m_err;
      end else begin
        e_frv = 1; e_frd = m_err ? 32'd0 : ref_word(m_adrs); e_fe = m_err;
      end
    end else if (fr || dr) begin
      m_own_d  = dr && !(fr && m_last_d);
      m_last_d = m_own_d;
      m_adrs   = m_own_d ? da : fa;
      m_err    = (m_adrs % 4 != 0) || (m_adrs > MEM_BYTES - 4);
      m_busy   = 1;
      if (m_own_d) e_dg = 1; else e_fg = 1;
      e_mem    = m_err ? 32'd0 : m_adrs;
    end
  endtask

  function automatic logic [31:0] rand_adrs();
    case ($urandom_range(0, 7))
      0:       return 32'($urandom_range(0, MEM_BYTES - 1));
      1:       return 32'd396;
      2:       return 32'd400 + 32'($urandom_range(0, 15));
      3:       return $urandom;
      default: return 32'($urandom_range(0, MEM_BYTES / 4 - 1) * 4);
    endcase
  endfunction

  localparam logic [31:0] F0   = 32'h20080005;
  localparam logic [31:0] W4   = 32'h04050607;
  localparam logic [31:0] W8   = 32'h08090A0B;
  localparam logic [31:0] W12  = 32'h0C0D0E0F;
  localparam logic [31:0] W20  = 32'h14151617;
  localparam logic [31:0] W24  = 32'h18191A1B;
  localparam logic [31:0] W396 = 32'h8C8D8E8F;

  initial begin
    bit cur_fg, cur_dg;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = i[7:0];
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    rst_n = 0; f_req = 0; f_adrs = 0; d_req = 0; d_adrs = 0;

    // reset with both requesting, then first fetch
    add(0, 1, 0, 1, 8,   pk(0,0,0,0, 0,0,0,0, 0));
    add(0, 1, 0, 1, 8,   pk(0,0,0,0, 0,0,0,0, 0));
    add(1, 1, 0, 0, 8,   pk(1,0,0,0, 0,0,0,0, 0));
    add(1, 0, 0, 0, 0,   pk(0,1,F0,0, 0,0,0,0, 0));
    add(1, 0, 0, 0, 0,   pk(0,0,F0,0, 0,0,0,0, 0));
    // contention: F was served last so D leads, then strict alternation
    add(1, 1, 4, 1, 8,   pk(0,0,F0,0, 1,0,0,0, 8));
    add(1, 1, 4, 1, 8,   pk(0,0,F0,0, 0,1,W8,0, 0));
    add(1, 1, 4, 1, 8,   pk(1,0,F0,0, 0,0,W8,0, 4));
    add(1, 1, 4, 1, 8,   pk(0,1,W4,0, 0,0,W8,0, 0));
    add(1, 1, 4, 1, 8,   pk(0,0,W4,0, 1,0,W8,0, 8));
    add(1, 0, 0, 0, 0,   pk(0,0,W4,0, 0,1,W8,0, 0));
    add(1, 0, 0, 0, 0,   pk(0,0,W4,0, 0,0,W8,0, 0));
    // error cases on D: misaligned, last word, just past the end
    add(1, 0, 0, 1, 2,   pk(0,0,W4,0, 1,0,W8,0, 0));
    add(1, 0, 0, 0, 2,   pk(0,0,W4,0, 0,1,0,1, 0));
    add(1, 0, 0, 1, 396, pk(0,0,W4,0, 1,0,0,1, 396));
    add(1, 0, 0, 1, 400, pk(0,0,W4,0, 0,1,W396,0, 0));
    add(1, 0, 0, 1, 400, pk(0,0,W4,0, 1,0,W396,0, 0));
    add(1, 0, 0, 0, 0,   pk(0,0,W4,0, 0,1,0,1, 0));
    add(1, 0, 0, 0, 0,   pk(0,0,W4,0, 0,0,0,1, 0));
    // F held across the RESP edge re-arms with the new address
    add(1, 1, 8, 0, 0,   pk(1,0,W4,0, 0,0,0,1, 8));
    add(1, 1, 12, 0, 0,  pk(0,1,W8,0, 0,0,0,1, 0));
    add(1, 1, 12, 0, 0,  pk(1,0,W8,0, 0,0,0,1, 12));
    add(1, 0, 0, 0, 0,   pk(0,1,W12,0, 0,0,0,1, 0));
    add(1, 0, 0, 0, 0,   pk(0,0,W12,0, 0,0,0,1, 0));
    // reset during ACCESS drops the transaction
    add(1, 1, 16, 0, 0,  pk(1,0,W12,0, 0,0,0,1, 16));
    add(0, 0, 0, 0, 0,   pk(0,0,0,0, 0,0,0,0, 0));
    add(1, 0, 0, 0, 0,   pk(0,0,0,0, 0,0,0,0, 0));
    add(1, 1, 24, 1, 20, pk(1,0,0,0, 0,0,0,0, 24));
    add(1, 0, 0, 1, 20,  pk(0,1,W24,0, 0,0,0,0, 0));
    add(1, 0, 0, 1, 20,  pk(0,0,W24,0, 1,0,0,0, 20));
    add(1, 0, 0, 0, 0,   pk(0,0,W24,0, 0,1,W20,0, 0));
    add(1, 0, 0, 0, 0,   pk(0,0,W24,0, 0,0,W20,0, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rn; f_req = tbl[i].fr; f_adrs = tbl[i].fa;
      d_req = tbl[i].dr; d_adrs = tbl[i].da;
      @(negedge clk);
      chk($sformatf("vec%0d", i), act, tbl[i].exp);
    end

    // lone D wins even though it was served last; late address change before the edge counts
    d_req = 1; d_adrs = 0;
    #2 d_adrs = 4;
    @(negedge clk);
    chk1("lone_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk1("late_adrs", mem_adrs, 32'd4);
    d_req = 0; d_adrs = 0;
    @(negedge clk);
    chk1("lone_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk1("lone_d_rdata", d_rdata, W4);
    chk1("lone_f_quiet", {30'd0, f_gnt, f_rvalid}, 32'd0);

    // randomized traffic
    cur_fg = 0; cur_dg = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        chk($sformatf("rand%0d", cyc), act,
            pk(e_fg, e_frv, e_frd, e_fe, e_dg, e_drv, e_drd, e_de, e_mem));
      end
      cur_fg = e_fg; cur_dg = e_dg;
      rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 79) != 0);
      if (f_req && !cur_fg) begin
        if ($urandom_range(0, 7) == 0) f_adrs = rand_adrs();
      end else begin
        f_req = $urandom_range(0, 1) != 0; f_adrs = rand_adrs();
      end
      if (d_req && !cur_dg) begin
        if ($urandom_range(0, 7) == 0) d_adrs = rand_adrs();
      end else begin
        d_req = $urandom_range(0, 2) == 0; d_adrs = rand_adrs();
      end
      model_step(rst_n, f_req, f_adrs, d_req, d_adrs);
    end
    @(negedge clk);
    chk("rand_last", act, pk(e_fg, e_frv, e_frd, e_fe, e_dg, e_drv, e_drd, e_de, e_mem));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
